i2c_tx_fifo: RTL and testbench

Synchronous byte FIFO between the APB slave register block and the I2C master core. The APB side pushes bytes with `W_ENA` and throttles on `WRITE_FULL`. The I2C side pops them with `R_ENA` and sees `READ_EMPTY`. The block adds an occupancy count, an almost-full watermark, sticky overflow/underflow error flags and a synchronous flush, so the APB side can report FIFO status.

---
 rtl/i2c_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_i2c_tx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tx_fifo.sv
// Byte FIFO between the APB register block and the I2C master core.
// Provides occupancy count, almost-full watermark, sticky error flags and flush.
module i2c_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  W_ENA,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  R_ENA,
    input  logic                  FLUSH,
    input  logic                  CLEAR_ERR,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  WRITE_FULL,
    output logic                  READ_EMPTY,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;

    // Status decode and acceptance; flush swallows any concurrent push or pop.
    always_comb begin
        full_s  = (count_q == DEPTH_CNT);
        empty_s = (count_q == CNT_ZERO);
        push_s  = W_ENA && !full_s && !FLUSH;
        pop_s   = R_ENA && !empty_s && !FLUSH;
    end

    // Next-state for pointers, occupancy and pop data.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (FLUSH) begin
            wptr_d  = PTR_ZERO;
            rptr_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + PTR_ONE;
                dout_d = mem_q[rptr_q];
            end else begin
                rptr_d = rptr_q;
                dout_d = dout_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Sticky error flags: a rejected request sets, CLEAR_ERR clears, set wins.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!FLUSH && W_ENA && full_s) begin
            ovf_d = 1'b1;
        end else if (CLEAR_ERR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (!FLUSH && R_ENA && empty_s) begin
            unf_d = 1'b1;
        end else if (CLEAR_ERR) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wptr_q  <= PTR_ZERO;
            rptr_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
            dout_q  <= DATA_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents need no reset because only written slots are ever read.
    always_ff @(posedge PCLK) begin
        if (push_s && !PRESET) begin
            mem_q[wptr_q] <= DATA_IN;
        end
    end

    assign DATA_OUT    = dout_q;
    assign COUNT       = count_q;
    assign WRITE_FULL  = full_s;
    assign READ_EMPTY  = empty_s;
    assign ALMOST_FULL = (count_q >= AFULL_CNT);
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Self-checking bench for i2c_tx_fifo: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_i2c_tx_fifo;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       W_ENA = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       R_ENA = 1'b0;
    logic       FLUSH = 1'b0;
    logic       CLEAR_ERR = 1'b0;
    logic [7:0] DATA_OUT;
    logic       WRITE_FULL;
    logic       READ_EMPTY;
    logic       ALMOST_FULL;
    logic [4:0] COUNT;
    logic       OVERFLOW;
    logic       UNDERFLOW;

    i2c_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .W_ENA(W_ENA), .DATA_IN(DATA_IN),
        .R_ENA(R_ENA), .FLUSH(FLUSH), .CLEAR_ERR(CLEAR_ERR),
        .DATA_OUT(DATA_OUT), .WRITE_FULL(WRITE_FULL), .READ_EMPTY(READ_EMPTY),
        .ALMOST_FULL(ALMOST_FULL), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, errors as plain bits.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit         m_ovf, m_unf, m_valid = 1'b0;

    always @(posedge PCLK) begin
        bit was_full, was_empty;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (PRESET) begin
            mq.delete();
            m_dout  = 8'h00;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (FLUSH) begin
            mq.delete();
            if (CLEAR_ERR) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            if (R_ENA && !was_empty) m_dout = mq.pop_front();
            if (W_ENA && !was_full) mq.push_back(DATA_IN);
            if (W_ENA && was_full) m_ovf = 1'b1;
            else if (CLEAR_ERR) m_ovf = 1'b0;
            if (R_ENA && was_empty) m_unf = 1'b1;
            else if (CLEAR_ERR) m_unf = 1'b0;
        end
        #1;
        if (m_valid) begin
            chk("count", COUNT, mq.size());
            chk("empty", READ_EMPTY, mq.size() == 0);
            chk("full", WRITE_FULL, mq.size() == 16);
            chk("afull", ALMOST_FULL, mq.size() >= 12);
            chk("data_out", DATA_OUT, m_dout);
            chk("overflow", OVERFLOW, m_ovf);
            chk("underflow", UNDERFLOW, m_unf);
        end
    end

    // One cycle of stimulus; returns after the edge has settled.
    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit f, input bit c, input bit p);
        @(negedge PCLK);
        W_ENA = w; DATA_IN = d; R_ENA = r; FLUSH = f; CLEAR_ERR = c; PRESET = p;
        @(posedge PCLK);
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp_q[$];

        // Reset for two cycles.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", COUNT, 0);
        chk("rst_empty", READ_EMPTY, 1);
        chk("rst_full", WRITE_FULL, 0);
        chk("rst_dout", DATA_OUT, 8'h00);
        chk("rst_errs", {OVERFLOW, UNDERFLOW}, 0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            if (i == 10) chk("afull_before_12", ALMOST_FULL, 0);
            if (i == 11) chk("afull_at_12", ALMOST_FULL, 1);
            if (i == 14) chk("not_full_at_15", WRITE_FULL, 0);
        end
        chk("fill_count", COUNT, 16);
        chk("fill_full", WRITE_FULL, 1);

        // Push while full with a concurrent pop.
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", OVERFLOW, 1);
        chk("ovf_count", COUNT, 15);
        chk("ovf_pop_oldest", DATA_OUT, 8'h00);
        for (int i = 1; i < 16; i++) begin
            pop();
            chk("drain_order", DATA_OUT, i);
        end
        chk("drain_empty", READ_EMPTY, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", OVERFLOW, 0);

        // Pop while empty with a concurrent push.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("unf_set", UNDERFLOW, 1);
        chk("unf_dout_held", DATA_OUT, 8'h0F);
        chk("unf_count", COUNT, 1);
        pop();
        chk("unf_next_pop", DATA_OUT, 8'h55);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("unf_cleared", UNDERFLOW, 0);

        // 40 push/pop pairs cross the pointer wrap twice.
        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom);
            push(v);
            pop();
            chk("wrap_data", DATA_OUT, v);
        end

        // Flush with a concurrent push; a prior underflow must survive it.
        pop();
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_count", COUNT, 0);
        chk("flush_empty", READ_EMPTY, 1);
        chk("flush_keeps_unf", UNDERFLOW, 1);
        chk("flush_keeps_ovf", OVERFLOW, 0);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
        pop();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midrst_count", COUNT, 0);
        chk("midrst_dout", DATA_OUT, 0);
        chk("midrst_unf", UNDERFLOW, 0);

        // Steady stream at occupancy 8.
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            exp_q.push_back(v);
            push(v);
        end
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom);
            exp_q.push_back(v);
            step(1'b1, v, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("stream_count", COUNT, 8);
            chk("stream_order", DATA_OUT, exp_q.pop_front());
        end

        // Randomized traffic with shifting push/pop bias.
        for (int seg = 0; seg < 8; seg++) begin
            int wp, rp;
            wp = (seg % 2 == 0) ? 80 : 25;
            rp = (seg % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 200; i++) begin
                bit f, p, c;
                p = ($urandom_range(0, 299) == 0);
                f = ($urandom_range(0, 59) == 0);
                c = ($urandom_range(0, 19) == 0);
                if (f) step(1'b0, 8'($urandom), 1'b0, 1'b1, c, p);
                else step($urandom_range(0, 99) < wp, 8'($urandom),
                          $urandom_range(0, 99) < rp, 1'b0, c, p);
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
